mult_share_ctrl: RTL

- Sequencing and arbitration controller that shares one combinational N-bit multiplier between two requesters.
- The multiplier computes the truncated low N bits of A*B; its inputs and output connect to this block's mult_a/mult_b/mult_c ports.
- The block latches the granted requester's operands and holds them stable for MULT_CYCLES cycles, treating the multiplier as a multicycle path.
- It captures the product and returns it with a one-cycle done pulse to the requester that issued it.

---
 rtl/mult_share_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mult_share_ctrl.sv
// rtl/mult_share_ctrl.sv - two-requester arbiter/sequencer for one shared multicycle multiplier
//
// Purpose: grants one of two requesters in round-robin order and latches its
// operands onto mult_a/mult_b. The operands are held for MULT_CYCLES cycles,
// mult_c is captured into result, and a done pulse goes to the granted requester.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   req0/a0/b0          - requester 0 level request and operands
//   req1/a1/b1          - requester 1 level request and operands
//   gnt0/gnt1           - one-cycle grant pulses
//   done0/done1         - one-cycle result-valid pulses
//   result              - last captured product (low N bits)
//   busy                - controller is not idle
//   mult_a/mult_b       - registered operands to the shared multiplier
//   mult_c              - product returned by the shared multiplier
module mult_share_ctrl #(
    parameter int N           = 8,
    parameter int MULT_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic [N-1:0] a0,
    input  logic [N-1:0] b0,
    input  logic         req1,
    input  logic [N-1:0] a1,
    input  logic [N-1:0] b1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic [N-1:0] result,
    output logic         busy,
    output logic [N-1:0] mult_a,
    output logic [N-1:0] mult_b,
    input  logic [N-1:0] mult_c
);

    localparam int CW = $clog2(MULT_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MULT_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          gnt0_q, gnt0_d;
    logic          gnt1_q, gnt1_d;
    logic          done0_q, done0_d;
    logic          done1_q, done1_d;
    logic [N-1:0]  result_q, result_d;
    logic [N-1:0]  mult_a_q, mult_a_d;
    logic [N-1:0]  mult_b_q, mult_b_d;
    logic          win1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        result_d = result_q;
        mult_a_d = mult_a_q;
        mult_b_d = mult_b_q;
        // Requester 1 wins when it is alone, or when both ask and 0 was served last.
        win1     = req1 && (!req0 || !last_q);

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    mult_a_d = win1 ? a1 : a0;
                    mult_b_d = win1 ? b1 : b0;
                    gnt0_d   = !win1;
                    gnt1_d   = win1;
                    last_d   = win1;
                    cnt_d    = CNT_LOAD;
                    state_d  = S_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    // last_q still names the requester whose operands are in flight.
                    result_d = mult_c;
                    done0_d  = !last_q;
                    done1_d  = last_q;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            result_q <= '0;
            mult_a_q <= '0;
            mult_b_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            result_q <= result_d;
            mult_a_q <= mult_a_d;
            mult_b_q <= mult_b_d;
        end
    end

    assign gnt0   = gnt0_q;
    assign gnt1   = gnt1_q;
    assign done0  = done0_q;
    assign done1  = done1_q;
    assign result = result_q;
    assign busy   = (state_q != S_IDLE);
    assign mult_a = mult_a_q;
    assign mult_b = mult_b_q;

endmodule
